fifo_stream_reader: RTL and testbench

- Read-side master for the team's synchronous fifo. Drains the fifo's pop interface (rd_en / dout / empty, one-cycle registered read latency) and presents the words in order on a valid/ready stream.
- Sits between the fifo read port and any downstream consumer.
- An internal 3-entry skid buffer hides the fifo read latency, so the stream sustains 1 word/cycle with no combinational path from m_ready to fifo_rd_en.

---
 rtl/fifo_stream_reader.sv | 98 +++++++++
 tb/tb_fifo_stream_reader.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Read-side master for a registered-read fifo; a 3-entry skid buffer hides the pop latency.
// Define FIFO_STREAM_READER_STALL_CNT_EN to build the saturating backpressure counter on stall_cnt.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  flush,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_empty,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic [CNT_WIDTH-1:0]  stall_cnt
);

  logic [DATA_WIDTH-1:0] mem [0:2];
  logic [1:0]            head;
  logic [1:0]            tail;
  logic [1:0]            occ;
  logic                  inflight;
  logic [2:0]            pending;
  logic                  capture;
  logic                  consume;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Reserving a slot for the in-flight word keeps the buffer from ever overflowing.
  assign pending    = {1'b0, occ} + {2'b00, inflight};
  assign fifo_rd_en = rst_n & en & ~fifo_empty & ~flush & (pending < 3'd3);

  assign m_valid = (occ != 2'd0);
  assign m_data  = mem[head];
  assign capture = inflight & ~flush;
  assign consume = m_valid & m_ready & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head     <= 2'd0;
      tail     <= 2'd0;
      occ      <= 2'd0;
      inflight <= 1'b0;
      rd_count <= '0;
    end else begin
      inflight <= fifo_rd_en;
      if (consume) begin
        rd_count <= rd_count + CNT_WIDTH'(1);
      end
      if (flush) begin
        head <= 2'd0;
        tail <= 2'd0;
        occ  <= 2'd0;
      end else begin
        if (capture) begin
          tail <= ptr_inc(tail);
        end
        if (consume) begin
          head <= ptr_inc(head);
        end
        case ({capture, consume})
          2'b10:   occ <= occ + 2'd1;
          2'b01:   occ <= occ - 2'd1;
          default: occ <= occ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        mem[i] <= '0;
      end
    end else if (capture) begin
      mem[tail] <= fifo_dout;
    end
  end

`ifdef FIFO_STREAM_READER_STALL_CNT_EN
  // Flush does not touch this counter; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (m_valid && !m_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_WIDTH'(1);
    end
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a small registered-read fifo model on its pop port.
module tb_fifo_stream_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        flush;
  logic        fifo_rd_en;
  logic [7:0]  fifo_dout = 8'd0;
  logic        fifo_empty;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_ready;
  logic [15:0] rd_count;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  logic [7:0] fifo_mem [0:255];
  logic [7:0] wr_ptr = 8'd0;
  logic [7:0] rd_ptr = 8'd0;

  fifo_stream_reader #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .flush      (flush),
    .fifo_rd_en (fifo_rd_en),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .rd_count   (rd_count),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  // Fifo model: one-cycle registered read data.
  assign fifo_empty = (rd_ptr == wr_ptr);
  always @(posedge clk) begin
    if (fifo_rd_en && !fifo_empty) begin
      fifo_dout <= fifo_mem[rd_ptr];
      rd_ptr    <= rd_ptr + 8'd1;
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic load(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      fifo_mem[wr_ptr] = first + 8'(i);
      wr_ptr = wr_ptr + 8'd1;
    end
  endtask

  task automatic restart(input logic [7:0] first, input int n, input logic en_v, input logic rdy_v);
    rst_n = 1'b0;
    flush = 1'b0;
    load(first, n);
    tick;
    en      = en_v;
    m_ready = rdy_v;
    rst_n   = 1'b1;
  endtask

  task automatic test_reset;
    rst_n   = 1'b0;
    en      = 1'b1;
    flush   = 1'b0;
    m_ready = 1'b1;
    load(8'd10, 16);
    tick;
    tick;
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_m_valid: got %b expected 0", m_valid); end
    checks++; if (m_data !== 8'd0) begin errors++; $display("[TB] FAIL reset_m_data: got %0d expected 0", m_data); end
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_en: got %b expected 0", fifo_rd_en); end
    checks++; if (rd_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_rd_count: got %0d expected 0", rd_count); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
  endtask

  task automatic test_stream;
    tick;
    rst_n = 1'b1;
    #1;
    checks++; if (fifo_rd_en !== 1'b1) begin errors++; $display("[TB] FAIL stream_first_pop: got %b expected 1", fifo_rd_en); end
    tick;
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL stream_startup_valid: got %b expected 0", m_valid); end
    tick;
    for (int k = 0; k < 16; k++) begin
      #1;
      checks++;
      if (m_valid !== 1'b1 || m_data !== 8'(10 + k)) begin
        errors++;
        $display("[TB] FAIL stream_word%0d: got valid=%b data=%0d expected valid=1 data=%0d", k, m_valid, m_data, 10 + k);
      end
      tick;
    end
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL stream_end_valid: got %b expected 0", m_valid); end
    checks++; if (rd_count !== 16'd16) begin errors++; $display("[TB] FAIL stream_rd_count: got %0d expected 16", rd_count); end
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL stream_empty_rd_en: got %b expected 0", fifo_rd_en); end
  endtask

  task automatic test_toggle;
    logic [7:0] exp_word;
    logic [7:0] held_val;
    logic       held;
    int         outst;
    int         cyc;
    restart(8'd10, 16, 1'b1, 1'b1);
    exp_word = 8'd10;
    held     = 1'b0;
    held_val = 8'd0;
    outst    = 0;
    cyc      = 0;
    while (exp_word != 8'd26 && cyc < 80) begin
      m_ready = (cyc % 2 == 0);
      #1;
      if (outst >= 3) begin
        checks++;
        if (fifo_rd_en !== 1'b0 || outst > 3) begin
          errors++;
          $display("[TB] FAIL toggle_full_rd_en: got rd_en=%b outstanding=%0d expected rd_en=0 outstanding<=3", fifo_rd_en, outst);
        end
      end
      if (held) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== held_val) begin
          errors++;
          $display("[TB] FAIL toggle_hold: got valid=%b data=%0d expected valid=1 data=%0d", m_valid, m_data, held_val);
        end
      end
      held = 1'b0;
      if (m_valid && m_ready) begin
        checks++;
        if (m_data !== exp_word) begin
          errors++;
          $display("[TB] FAIL toggle_order: got %0d expected %0d", m_data, exp_word);
        end
        exp_word = exp_word + 8'd1;
        outst--;
      end else if (m_valid) begin
        held     = 1'b1;
        held_val = m_data;
      end
      if (fifo_rd_en) outst++;
      cyc++;
      tick;
    end
    m_ready = 1'b1;
    #1;
    checks++; if (exp_word !== 8'd26) begin errors++; $display("[TB] FAIL toggle_delivered: got next=%0d expected 26", exp_word); end
    checks++; if (rd_count !== 16'd16) begin errors++; $display("[TB] FAIL toggle_rd_count: got %0d expected 16", rd_count); end
  endtask

  task automatic test_backpressure;
    int         pops;
    int         n;
    logic [7:0] exp_word;
    restart(8'd40, 5, 1'b1, 1'b0);
    pops = 0;
    repeat (10) begin
      #1;
      if (fifo_rd_en) pops++;
      tick;
    end
    #1;
    checks++; if (pops != 3) begin errors++; $display("[TB] FAIL bp_pops: got %0d expected 3", pops); end
    checks++; if (m_valid !== 1'b1 || m_data !== 8'd40) begin errors++; $display("[TB] FAIL bp_head: got valid=%b data=%0d expected valid=1 data=40", m_valid, m_data); end
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL bp_full_rd_en: got %b expected 0", fifo_rd_en); end
    m_ready  = 1'b1;
    exp_word = 8'd40;
    n        = 0;
    while (exp_word != 8'd45 && n < 20) begin
      #1;
      if (m_valid) begin
        checks++;
        if (m_data !== exp_word) begin errors++; $display("[TB] FAIL bp_order: got %0d expected %0d", m_data, exp_word); end
        exp_word = exp_word + 8'd1;
      end
      n++;
      tick;
    end
    #1;
    checks++; if (exp_word !== 8'd45) begin errors++; $display("[TB] FAIL bp_delivered: got next=%0d expected 45", exp_word); end
    checks++; if (rd_count !== 16'd5) begin errors++; $display("[TB] FAIL bp_rd_count: got %0d expected 5", rd_count); end
  endtask

  task automatic test_flush;
    int         n;
    logic [7:0] exp_word;
    restart(8'd60, 7, 1'b1, 1'b0);
    #1; tick;
    #1; tick;
    m_ready = 1'b1;
    #1;
    checks++; if (m_valid !== 1'b1 || m_data !== 8'd60) begin errors++; $display("[TB] FAIL flush_first: got valid=%b data=%0d expected valid=1 data=60", m_valid, m_data); end
    tick;
    m_ready = 1'b0;
    #1; tick;
    flush   = 1'b1;
    m_ready = 1'b1;
    #1;
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL flush_rd_en_busy: got %b expected 0", fifo_rd_en); end
    checks++; if (m_valid !== 1'b1 || m_data !== 8'd61) begin errors++; $display("[TB] FAIL flush_pre_head: got valid=%b data=%0d expected valid=1 data=61", m_valid, m_data); end
    tick;
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_valid: got %b expected 0", m_valid); end
    checks++; if (rd_count !== 16'd1) begin errors++; $display("[TB] FAIL flush_rd_count: got %0d expected 1", rd_count); end
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL flush_rd_en_forced: got %b expected 0", fifo_rd_en); end
    tick;
    flush    = 1'b0;
    exp_word = 8'd64;
    n        = 0;
    while (exp_word != 8'd67 && n < 20) begin
      #1;
      if (m_valid) begin
        checks++;
        if (m_data !== exp_word) begin errors++; $display("[TB] FAIL flush_after: got %0d expected %0d", m_data, exp_word); end
        exp_word = exp_word + 8'd1;
      end
      n++;
      tick;
    end
    #1;
    checks++; if (exp_word !== 8'd67) begin errors++; $display("[TB] FAIL flush_delivered: got next=%0d expected 67", exp_word); end
    checks++; if (rd_count !== 16'd4) begin errors++; $display("[TB] FAIL flush_rd_count_end: got %0d expected 4", rd_count); end
  endtask

  task automatic test_enable;
    int         n;
    logic [7:0] exp_word;
    restart(8'd80, 4, 1'b1, 1'b1);
    #1;
    checks++; if (fifo_rd_en !== 1'b1) begin errors++; $display("[TB] FAIL en_first_pop: got %b expected 1", fifo_rd_en); end
    tick;
    en = 1'b0;
    #1;
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL en_off_rd_en: got %b expected 0", fifo_rd_en); end
    tick;
    #1;
    checks++; if (m_valid !== 1'b1 || m_data !== 8'd80) begin errors++; $display("[TB] FAIL en_inflight: got valid=%b data=%0d expected valid=1 data=80", m_valid, m_data); end
    tick;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (fifo_rd_en !== 1'b0 || m_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL en_idle%0d: got rd_en=%b valid=%b expected rd_en=0 valid=0", k, fifo_rd_en, m_valid);
      end
      tick;
    end
    en       = 1'b1;
    exp_word = 8'd81;
    n        = 0;
    while (exp_word != 8'd84 && n < 20) begin
      #1;
      if (m_valid) begin
        checks++;
        if (m_data !== exp_word) begin errors++; $display("[TB] FAIL en_resume: got %0d expected %0d", m_data, exp_word); end
        exp_word = exp_word + 8'd1;
      end
      n++;
      tick;
    end
    #1;
    checks++; if (exp_word !== 8'd84) begin errors++; $display("[TB] FAIL en_delivered: got next=%0d expected 84", exp_word); end
    checks++; if (rd_count !== 16'd4) begin errors++; $display("[TB] FAIL en_rd_count: got %0d expected 4", rd_count); end
  endtask

  task automatic test_reset_mid;
    logic [15:0] exp_stall;
`ifdef FIFO_STREAM_READER_STALL_CNT_EN
    exp_stall = 16'd7;
`else
    exp_stall = 16'd0;
`endif
    restart(8'd90, 10, 1'b1, 1'b1);
    #1; tick;
    #1; tick;
    #1;
    checks++; if (m_valid !== 1'b1 || m_data !== 8'd90) begin errors++; $display("[TB] FAIL mid_first: got valid=%b data=%0d expected valid=1 data=90", m_valid, m_data); end
    tick;
    en      = 1'b0;
    m_ready = 1'b0;
    repeat (7) tick;
    en = 1'b1;
    #1;
    checks++; if (m_valid !== 1'b1 || m_data !== 8'd91) begin errors++; $display("[TB] FAIL mid_head: got valid=%b data=%0d expected valid=1 data=91", m_valid, m_data); end
    checks++; if (fifo_rd_en !== 1'b1) begin errors++; $display("[TB] FAIL mid_rd_en: got %b expected 1", fifo_rd_en); end
    checks++; if (rd_count !== 16'd1) begin errors++; $display("[TB] FAIL mid_rd_count: got %0d expected 1", rd_count); end
    checks++; if (stall_cnt !== exp_stall) begin errors++; $display("[TB] FAIL mid_stall_cnt: got %0d expected %0d", stall_cnt, exp_stall); end
    rst_n = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL async_m_valid: got %b expected 0", m_valid); end
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL async_rd_en: got %b expected 0", fifo_rd_en); end
    checks++; if (rd_count !== 16'd0) begin errors++; $display("[TB] FAIL async_rd_count: got %0d expected 0", rd_count); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("[TB] FAIL async_stall_cnt: got %0d expected 0", stall_cnt); end
    checks++; if (m_data !== 8'd0) begin errors++; $display("[TB] FAIL async_m_data: got %0d expected 0", m_data); end
  endtask

  initial begin
    $display("[TB] fifo_stream_reader directed tests");
    test_reset;
    test_stream;
    test_toggle;
    test_backpressure;
    test_flush;
    test_enable;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
